// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4)+overall-parity controller:
// FSM states, codeword bit positions, syndrome masks and the encoder.
package hamming_pkg;

  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    CODIFICAR   = 3'd1,
    INYECTAR    = 3'd2,
    DECODIFICAR = 3'd3,
    CORREGIR    = 3'd4,
    REPORTAR    = 3'd5
  } estado_t;

  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_PT = 7;

  // Each syndrome bit is the parity of the received bits selected by its mask
  localparam logic [7:0] MASCARA_S1 = 8'h55;
  localparam logic [7:0] MASCARA_S2 = 8'h66;
  localparam logic [7:0] MASCARA_S3 = 8'h78;

  function automatic logic [7:0] codificar(input logic [3:0] d);
    logic [7:0] w;
    w         = '0;
    w[POS_D0] = d[0];
    w[POS_D1] = d[1];
    w[POS_D2] = d[2];
    w[POS_D3] = d[3];
    w[POS_P1] = d[0] ^ d[1] ^ d[3];
    w[POS_P2] = d[0] ^ d[2] ^ d[3];
    w[POS_P4] = d[1] ^ d[2] ^ d[3];
    w[POS_PT] = ^w[6:0];
    return w;
  endfunction

  function automatic logic [2:0] sindrome_de(input logic [7:0] r);
    return {^(r & MASCARA_S3), ^(r & MASCARA_S2), ^(r & MASCARA_S1)};
  endfunction

endpackage

// File: rtl/hamming_nucleo.sv
// Combinational SECDED core: encodes a nibble, and for a received codeword
// produces the syndrome, the error class and the corrected nibble.
module hamming_nucleo
  import hamming_pkg::*;
(
  input  logic [3:0] dato,
  output logic [7:0] palabra,
  input  logic [7:0] recibido,
  output logic [2:0] sindrome,
  output logic       simple,
  output logic       doble,
  output logic [3:0] corregido
);

  logic       st;
  logic [7:0] volteo;
  logic [7:0] reparado;

  always_comb begin
    palabra  = codificar(dato);
    sindrome = sindrome_de(recibido);
    st       = ^recibido;
    simple   = st;
    doble    = !st && (sindrome != 3'd0);
    volteo   = '0;
    // A zero syndrome with odd overall parity means the parity bit itself flipped
    if (st) begin
      if (sindrome == 3'd0) volteo[POS_PT] = 1'b1;
      else                  volteo[sindrome - 3'd1] = 1'b1;
    end
    reparado  = recibido ^ volteo;
    corregido = {reparado[POS_D3], reparado[POS_D2], reparado[POS_D1], reparado[POS_D0]};
  end

endmodule

// File: rtl/control_hamming.sv
// Handshaked SECDED encode/inject/decode controller with error counters.
// Define HAMMING_CONTADORES_EN to build the saturating error counters.
module control_hamming
  import hamming_pkg::*;
#(
  parameter int ANCHO_CONT = 8
) (
  input  logic                  reloj,
  input  logic                  reset,
  input  logic                  entrada_valida,
  output logic                  entrada_lista,
  input  logic [3:0]            dato_entrada,
  input  logic [7:0]            mascara_error,
  output logic                  salida_valida,
  input  logic                  salida_lista,
  output logic [3:0]            corregido,
  output logic [2:0]            sindrome,
  output logic                  simplerror_detectado,
  output logic                  doblerror_detectado,
  output logic [ANCHO_CONT-1:0] cont_simple,
  output logic [ANCHO_CONT-1:0] cont_doble,
  output logic                  ocupado
);

  estado_t    estado, estado_sig;
  logic       acepta;
  logic [3:0] dato_p0;
  logic [7:0] mascara_p0;
  logic [7:0] palabra_p1;
  logic [7:0] recibido_p2;
  logic [2:0] sindrome_p3;
  logic       simple_p3;
  logic       doble_p3;

  logic [7:0] palabra_n;
  logic [2:0] sindrome_n;
  logic       simple_n;
  logic       doble_n;
  logic [3:0] corregido_n;

  hamming_nucleo u_nucleo (
    .dato      (dato_p0),
    .palabra   (palabra_n),
    .recibido  (recibido_p2),
    .sindrome  (sindrome_n),
    .simple    (simple_n),
    .doble     (doble_n),
    .corregido (corregido_n)
  );

  assign entrada_lista = (estado == REPOSO);
  assign acepta        = entrada_valida && entrada_lista;
  assign salida_valida = (estado == REPORTAR);
  assign ocupado       = (estado != REPOSO);

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:      if (acepta) estado_sig = CODIFICAR;
      CODIFICAR:   estado_sig = INYECTAR;
      INYECTAR:    estado_sig = DECODIFICAR;
      DECODIFICAR: estado_sig = CORREGIR;
      CORREGIR:    estado_sig = REPORTAR;
      REPORTAR:    if (salida_lista) estado_sig = REPOSO;
      default:     estado_sig = REPOSO;
    endcase
  end

  // p0 capture -> p1 encode -> p2 inject -> p3 syndrome/class
  always_ff @(posedge reloj) begin
    if (acepta) begin
      dato_p0    <= dato_entrada;
      mascara_p0 <= mascara_error;
    end
    if (estado == CODIFICAR) palabra_p1 <= palabra_n;
    if (estado == INYECTAR)  recibido_p2 <= palabra_p1 ^ mascara_p0;
    if (estado == DECODIFICAR) begin
      sindrome_p3 <= sindrome_n;
      simple_p3   <= simple_n;
      doble_p3    <= doble_n;
    end
  end

  // Result registers load on CORREGIR -> REPORTAR and hold until the next word
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      corregido            <= '0;
      sindrome             <= '0;
      simplerror_detectado <= 1'b0;
      doblerror_detectado  <= 1'b0;
    end else if (estado == CORREGIR) begin
      corregido            <= corregido_n;
      sindrome             <= sindrome_p3;
      simplerror_detectado <= simple_p3;
      doblerror_detectado  <= doble_p3;
    end
  end

`ifdef HAMMING_CONTADORES_EN
  function automatic logic [ANCHO_CONT-1:0] incr_saturado(input logic [ANCHO_CONT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      cont_simple <= '0;
      cont_doble  <= '0;
    end else if (estado == CORREGIR) begin
      if (simple_p3) cont_simple <= incr_saturado(cont_simple);
      if (doble_p3)  cont_doble  <= incr_saturado(cont_doble);
    end
  end
`else
  assign cont_simple = '0;
  assign cont_doble  = '0;
`endif

endmodule

// File: tb/tb_control_hamming.sv
// Scoreboard bench for control_hamming: a bench-side SECDED model pushes
// expected results at each accept; they are popped when salida_valida rises.
module tb_control_hamming;

  localparam int ANCHO = 2;
  localparam int MAXC  = (1 << ANCHO) - 1;

  logic             reloj;
  logic             reset;
  logic             entrada_valida;
  logic             entrada_lista;
  logic [3:0]       dato_entrada;
  logic [7:0]       mascara_error;
  logic             salida_valida;
  logic             salida_lista;
  logic [3:0]       corregido;
  logic [2:0]       sindrome;
  logic             simplerror_detectado;
  logic             doblerror_detectado;
  logic [ANCHO-1:0] cont_simple;
  logic [ANCHO-1:0] cont_doble;
  logic             ocupado;

  control_hamming #(.ANCHO_CONT(ANCHO)) dut (
    .reloj                (reloj),
    .reset                (reset),
    .entrada_valida       (entrada_valida),
    .entrada_lista        (entrada_lista),
    .dato_entrada         (dato_entrada),
    .mascara_error        (mascara_error),
    .salida_valida        (salida_valida),
    .salida_lista         (salida_lista),
    .corregido            (corregido),
    .sindrome             (sindrome),
    .simplerror_detectado (simplerror_detectado),
    .doblerror_detectado  (doblerror_detectado),
    .cont_simple          (cont_simple),
    .cont_doble           (cont_doble),
    .ocupado              (ocupado)
  );

  typedef struct {
    logic [3:0] corr;
    logic [2:0] sind;
    logic       simp;
    logic       dob;
    int         cs;
    int         cd;
  } esperado_t;

  esperado_t cola[$];
  int checks = 0;
  int fallos = 0;
  int cs_mod = 0;
  int cd_mod = 0;

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      fallos++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic empujar(input logic [3:0] d, input logic [7:0] m);
    esperado_t  e;
    logic [7:0] c, r;
    logic [2:0] s;
    logic       st;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[7] = c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[4] ^ c[5] ^ c[6];
    r = c ^ m;
    s = {r[3] ^ r[4] ^ r[5] ^ r[6], r[1] ^ r[2] ^ r[5] ^ r[6], r[0] ^ r[2] ^ r[4] ^ r[6]};
    st = ^r;
    e.sind = s;
    e.simp = st;
    e.dob  = !st && (s != 3'd0);
    if (st) begin
      if (s == 3'd0) r[7] = ~r[7];
      else           r[int'(s) - 1] = ~r[int'(s) - 1];
    end
    e.corr = {r[6], r[5], r[4], r[2]};
`ifdef HAMMING_CONTADORES_EN
    if (e.simp && cs_mod < MAXC) cs_mod++;
    if (e.dob  && cd_mod < MAXC) cd_mod++;
`endif
    e.cs = cs_mod;
    e.cd = cd_mod;
    cola.push_back(e);
  endtask

  task automatic enviar(input logic [3:0] d, input logic [7:0] m, input int espera);
    esperado_t e;
    int        ciclos;
    @(negedge reloj);
    dato_entrada   = d;
    mascara_error  = m;
    entrada_valida = 1'b1;
    comprobar("lista_en_reposo", entrada_lista, 1);
    @(posedge reloj);
    empujar(d, m);
    #1;
    entrada_valida = 1'b0;
    dato_entrada   = ~d;
    mascara_error  = ~m;
    comprobar("ocupado_tras_aceptar", ocupado, 1);
    ciclos = 1;
    while (salida_valida !== 1'b1 && ciclos < 20) begin
      @(posedge reloj);
      #1;
      ciclos++;
    end
    comprobar("latencia", ciclos, 5);
    e = cola.pop_front();
    if (salida_valida !== 1'b1) return;
    comprobar("corregido", corregido, e.corr);
    comprobar("sindrome", sindrome, e.sind);
    comprobar("simple", simplerror_detectado, e.simp);
    comprobar("doble", doblerror_detectado, e.dob);
    comprobar("cont_simple", cont_simple, e.cs);
    comprobar("cont_doble", cont_doble, e.cd);
    comprobar("exclusivos", simplerror_detectado & doblerror_detectado, 0);
    for (int i = 0; i < espera; i++) begin
      @(posedge reloj);
      #1;
      comprobar("espera_valida", {salida_valida, entrada_lista}, 2'b10);
      comprobar("espera_corregido", corregido, e.corr);
      comprobar("espera_sindrome", sindrome, e.sind);
    end
    @(negedge reloj);
    salida_lista = 1'b1;
    @(posedge reloj);
    #1;
    salida_lista = 1'b0;
    comprobar("vuelta_reposo", {salida_valida, entrada_lista, ocupado}, 3'b010);
  endtask

  task automatic reset_en_decodificar();
    @(negedge reloj);
    dato_entrada   = 4'b0110;
    mascara_error  = 8'h01;
    entrada_valida = 1'b1;
    @(posedge reloj);
    #1;
    entrada_valida = 1'b0;
    repeat (2) @(posedge reloj);
    #1;
    comprobar("ocupado_en_decodificar", ocupado, 1);
    reset = 1'b1;
    #1;
    comprobar("rst_vuelo_valida", salida_valida, 0);
    comprobar("rst_vuelo_ocupado", ocupado, 0);
    comprobar("rst_vuelo_resultado", {corregido, sindrome, simplerror_detectado, doblerror_detectado}, 0);
    comprobar("rst_vuelo_contadores", {cont_simple, cont_doble}, 0);
    @(negedge reloj);
    reset  = 1'b0;
    cs_mod = 0;
    cd_mod = 0;
    repeat (6) @(negedge reloj);
    comprobar("sin_resultado_fantasma", {salida_valida, entrada_lista}, 2'b01);
  endtask

  initial begin
    logic [3:0] d;
    logic [7:0] m;
    reset          = 1'b1;
    entrada_valida = 1'b0;
    dato_entrada   = '0;
    mascara_error  = '0;
    salida_lista   = 1'b0;
    #12;
    comprobar("rst_valida", salida_valida, 0);
    comprobar("rst_ocupado", ocupado, 0);
    comprobar("rst_resultado", {corregido, sindrome, simplerror_detectado, doblerror_detectado}, 0);
    comprobar("rst_contadores", {cont_simple, cont_doble}, 0);
    @(negedge reloj);
    reset = 1'b0;
    @(negedge reloj);
    comprobar("rst_lista", entrada_lista, 1);

    enviar(4'b1010, 8'h00, 0);
    enviar(4'b1010, 8'h01, 0);
    enviar(4'b1010, 8'h80, 0);
    enviar(4'b1010, 8'h05, 10);

    reset_en_decodificar();
    enviar(4'b1010, 8'h00, 0);

    for (int i = 0; i < 5; i++) begin
      d = 4'($urandom);
      m = 8'(1 << $urandom_range(0, 7));
      enviar(d, m, 0);
    end
    for (int i = 0; i < 6; i++) begin
      d = 4'($urandom);
      m = 8'($urandom);
      enviar(d, m, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fallos);
    $finish;
  end

endmodule
